// File: rtl/somador_4bits_pkg.sv
// Shared definitions for the registered 4-bit ripple-carry adder.
package somador_4bits_pkg;

    localparam int SOMADOR_WIDTH = 4;

    typedef logic [SOMADOR_WIDTH-1:0] operand_t;

endpackage : somador_4bits_pkg

// File: rtl/somador_4bits_if.sv
// Operand/result bundle of the registered adder; master drives operands, slave returns the sum.
interface somador_4bits_if #(
    parameter int WIDTH = somador_4bits_pkg::SOMADOR_WIDTH
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output a,
        output b,
        input  sum,
        input  carry_out
    );

    modport slave (
        input  a,
        input  b,
        output sum,
        output carry_out
    );

endinterface : somador_4bits_if

// File: rtl/somador_4bits_full_adder.sv
// One-bit full adder cell; the top chains WIDTH of these into a ripple adder.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_s;

    assign half_s = x ^ y;
    assign s      = half_s ^ cin;
    assign cout   = (x & y) | (cin & half_s);

endmodule : full_adder

// File: rtl/somador_4bits.sv
// Registered unsigned ripple-carry adder: {carry_out, sum} = a + b, one cycle after capture.
module somador_4bits
    import somador_4bits_pkg::*;
#(
    parameter int WIDTH = SOMADOR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    somador_4bits_if.slave       bus
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH:0]   result_r;

    assign carry_s[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_stage
            full_adder u_fa (
                .x    (bus.a[i]),
                .y    (bus.b[i]),
                .cin  (carry_s[i]),
                .s    (sum_s[i]),
                .cout (carry_s[i+1])
            );
        end
    endgenerate

    // Output register: reset wins over the operands captured on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= {(WIDTH+1){1'b0}};
        end else begin
            result_r <= {carry_s[WIDTH], sum_s};
        end
    end

    assign bus.sum       = result_r[WIDTH-1:0];
    assign bus.carry_out = result_r[WIDTH];

endmodule : somador_4bits

// File: tb/tb_somador_4bits.sv
// Scoreboard bench for somador_4bits: driver pushes a+b expectations, monitor pops one per edge.
module tb_somador_4bits;
    import somador_4bits_pkg::*;

    typedef struct {
        int    exp_sum;
        int    exp_carry;
        string name;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   n_compared;
    int   n_mismatched;

    somador_4bits_if #(.WIDTH(SOMADOR_WIDTH)) bus ();

    somador_4bits #(.WIDTH(SOMADOR_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer addition, split into mod-16 sum and overflow bit.
    task automatic apply(input logic r, input int av, input int bv, input string nm);
        exp_t e;
        int   total;
        @(negedge clk);
        rst   = r;
        bus.a = operand_t'(av);
        bus.b = operand_t'(bv);
        total = r ? 0 : (av + bv);
        e.exp_sum   = total % 16;
        e.exp_carry = total / 16;
        e.name      = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: every rising edge produces one result, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_compared++;
                if (bus.sum !== 4'(e.exp_sum) || bus.carry_out !== 1'(e.exp_carry)) begin
                    n_mismatched++;
                    $display("FAIL %s: got sum=%0d carry=%b, expected sum=%0d carry=%0d",
                             e.name, bus.sum, bus.carry_out, e.exp_sum, e.exp_carry);
                end
            end
        end
    end

    initial begin
        int ra;
        int rb;
        n_compared   = 0;
        n_mismatched = 0;
        rst   = 1'b0;
        bus.a = 4'd0;
        bus.b = 4'd0;

        apply(1'b1, 9, 9, "reset_edge1");
        apply(1'b1, 9, 9, "reset_edge2");
        apply(1'b0, 9, 9, "release_9p9");

        apply(1'b0, 0, 0, "small_0p0");
        apply(1'b0, 0, 1, "small_0p1");
        apply(1'b0, 1, 1, "small_1p1");
        apply(1'b0, 3, 1, "small_3p1");
        apply(1'b0, 3, 3, "small_3p3");
        apply(1'b0, 4, 3, "small_4p3");
        apply(1'b0, 7, 7, "small_7p7");

        apply(1'b0, 15, 15, "ovf_15p15");
        apply(1'b0, 1, 15, "ovf_1p15_ripple");
        apply(1'b0, 0, 0, "back_to_zero");

        apply(1'b0, 5, 6, "stream_5p6");
        apply(1'b0, 8, 8, "stream_8p8");
        apply(1'b0, 2, 1, "stream_2p1");

        for (int k = 0; k < 40; k++) begin
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            apply(1'b0, ra, rb, "random");
        end

        apply(1'b1, 12, 7, "midstream_reset");
        apply(1'b0, 12, 7, "after_reset_12p7");

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                apply(1'b0, i, j, "exhaustive");
            end
        end

        repeat (3) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_somador_4bits
